// File: rtl/uncached_bridge_pkg.sv
// Shared bus widths, AXI response codes and transfer-size encodings for the uncached bridge.
package uncached_bridge_pkg;
    localparam int ADDR_BUS = 32;
    localparam int DATA_BUS = 32;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;
endpackage

// File: rtl/uncached_bridge.sv
// Single-outstanding bridge turning a stalling CPU uncached request into one AXI read or write.
module uncached_bridge
    import uncached_bridge_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_en,
    input  logic                req_we,
    input  logic [3:0]          req_sel,
    input  logic [ADDR_BUS-1:0] req_addr,
    input  logic [DATA_BUS-1:0] req_wdata,
    output logic                req_stall,
    output logic [DATA_BUS-1:0] req_rdata,
    output logic                bus_err,
    output logic [ADDR_BUS-1:0] araddr,
    output logic [2:0]          arsize,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_BUS-1:0] rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_BUS-1:0] awaddr,
    output logic [2:0]          awsize,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_BUS-1:0] wdata,
    output logic [3:0]          wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW_W = 3'd3,
        S_B    = 3'd4,
        S_DONE = 3'd5
    } state_t;

    function automatic logic [2:0] size_from_sel(input logic [3:0] sel);
        case (sel)
            4'b1111:          size_from_sel = SIZE_WORD;
            4'b0011, 4'b1100: size_from_sel = SIZE_HALF;
            default:          size_from_sel = SIZE_BYTE;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_BUS-1:0] addr_q, addr_d;
    logic [3:0]          sel_q, sel_d;
    logic [DATA_BUS-1:0] wdata_q, wdata_d;
    logic [DATA_BUS-1:0] rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                aw_hs, w_hs;

    assign aw_hs = (state_q == S_AW_W) && !aw_done_q && awready;
    assign w_hs  = (state_q == S_AW_W) && !w_done_q && wready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            S_IDLE: begin
                if (req_en) begin
                    addr_d    = req_addr;
                    sel_d     = req_sel;
                    wdata_d   = req_wdata;
                    rdata_d   = '0;
                    resp_d    = RESP_OKAY;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_we ? S_AW_W : S_AR;
                end
            end
            S_AR: if (arready) state_d = S_R;
            S_R: begin
                if (rvalid) begin
                    rdata_d = rdata;
                    resp_d  = rresp;
                    state_d = S_DONE;
                end
            end
            S_AW_W: begin
                // Address and data handshakes may land in either order or together.
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_B;
            end
            S_B: begin
                if (bvalid) begin
                    resp_d  = bresp;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            sel_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Outputs are forced quiet while rst is high, even before the first reset edge lands.
    assign req_stall = req_en && (state_q != S_DONE) && !rst;
    assign req_rdata = rst ? '0 : rdata_q;
    assign bus_err   = !rst && (state_q == S_DONE) && (resp_q != RESP_OKAY);

    assign arvalid = !rst && (state_q == S_AR);
    assign rready  = !rst && (state_q == S_R);
    assign awvalid = !rst && (state_q == S_AW_W) && !aw_done_q;
    assign wvalid  = !rst && (state_q == S_AW_W) && !w_done_q;
    assign bready  = !rst && (state_q == S_B);

    assign araddr = rst ? '0 : addr_q;
    assign awaddr = rst ? '0 : addr_q;
    assign arsize = rst ? 3'd0 : size_from_sel(sel_q);
    assign awsize = rst ? 3'd0 : size_from_sel(sel_q);
    assign wstrb  = rst ? 4'd0 : sel_q;
    assign wdata  = rst ? '0 : wdata_q;
endmodule

// File: tb/tb_uncached_bridge.sv
// Directed bench for uncached_bridge: vector table with immediate slave plus multi-cycle corner sequences.
module tb_uncached_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_en, req_we;
    logic [3:0]  req_sel;
    logic [31:0] req_addr, req_wdata;
    logic        req_stall;
    logic [31:0] req_rdata;
    logic        bus_err;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    always #5 clk = ~clk;

    uncached_bridge dut (
        .clk(clk), .rst(rst),
        .req_en(req_en), .req_we(req_we), .req_sel(req_sel), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_stall(req_stall), .req_rdata(req_rdata), .bus_err(bus_err),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [1:0]  resp;
        logic [2:0]  exp_size;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    endtask

    always @(negedge clk) begin
        if (arvalid && awvalid) begin
            errors++;
            $display("FAIL ar_aw_overlap actual=1 required=0");
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        int k;
        int ar_n, aw_n, w_n;
        bit done;
        req_en = 1'b1; req_we = v.we; req_sel = v.sel; req_addr = v.addr; req_wdata = v.wd;
        arready = 1'b1; rvalid = 1'b1; rdata = v.rd; rresp = v.resp;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = v.resp;
        ar_n = 0; aw_n = 0; w_n = 0; done = 1'b0;
        for (k = 0; k < 16; k++) begin
            @(negedge clk);
            if (!req_stall) begin
                done = 1'b1;
                break;
            end
            if (arvalid) begin
                ar_n++;
                chk($sformatf("v%0d_araddr", idx), araddr, v.addr);
                chk($sformatf("v%0d_arsize", idx), 32'(arsize), 32'(v.exp_size));
            end
            if (awvalid) begin
                aw_n++;
                chk($sformatf("v%0d_awaddr", idx), awaddr, v.addr);
                chk($sformatf("v%0d_awsize", idx), 32'(awsize), 32'(v.exp_size));
            end
            if (wvalid) begin
                w_n++;
                chk($sformatf("v%0d_wstrb", idx), 32'(wstrb), 32'(v.sel));
                chk($sformatf("v%0d_wdata", idx), wdata, v.wd);
            end
            cyc();
        end
        chk($sformatf("v%0d_completed", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d_latency", idx), 32'(k), 32'd3);
        chk($sformatf("v%0d_rdata", idx), req_rdata, v.exp_rdata);
        chk($sformatf("v%0d_bus_err", idx), 32'(bus_err), 32'(v.exp_err));
        chk($sformatf("v%0d_ar_cycles", idx), 32'(ar_n), v.we ? 32'd0 : 32'd1);
        chk($sformatf("v%0d_aw_cycles", idx), 32'(aw_n), v.we ? 32'd1 : 32'd0);
        chk($sformatf("v%0d_w_cycles", idx), 32'(w_n), v.we ? 32'd1 : 32'd0);
        cyc();
        req_en = 1'b0;
        slave_idle();
        @(negedge clk);
        chk($sformatf("v%0d_err_after", idx), 32'(bus_err), 32'd0);
        chk($sformatf("v%0d_stall_after", idx), 32'(req_stall), 32'd0);
        chk($sformatf("v%0d_idle_valids", idx), 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 4'b1111, 32'h1FAF_0000, 32'h0,         32'hDEAD_BEEF, 2'b00, 3'd2, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b1, 4'b0100, 32'h1FD0_03F8, 32'h00AB_0000, 32'hFFFF_FFFF, 2'b00, 3'd0, 32'h0,         1'b0};
        vecs[2] = '{1'b0, 4'b1100, 32'h1000_0002, 32'h0,         32'h1234_5678, 2'b00, 3'd1, 32'h1234_5678, 1'b0};
        vecs[3] = '{1'b0, 4'b0010, 32'h1FB0_0001, 32'h0,         32'hCAFE_F00D, 2'b10, 3'd0, 32'hCAFE_F00D, 1'b1};
        vecs[4] = '{1'b1, 4'b1111, 32'h1FD0_0000, 32'h0123_4567, 32'hFFFF_FFFF, 2'b11, 3'd2, 32'h0,         1'b1};
        vecs[5] = '{1'b1, 4'b0011, 32'h1FD0_0102, 32'h0000_BEEF, 32'hFFFF_FFFF, 2'b00, 3'd1, 32'h0,         1'b0};
        vecs[6] = '{1'b0, 4'b1000, 32'h1FD0_03FB, 32'h0,         32'hAB00_0000, 2'b00, 3'd0, 32'hAB00_0000, 1'b0};

        // Reset: outputs quiet even with a request pending.
        rst = 1'b1; req_en = 1'b1; req_we = 1'b1; req_sel = 4'b1111;
        req_addr = 32'h1234_5678; req_wdata = 32'h8765_4321;
        slave_idle();
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_stall", 32'(req_stall), 32'd0);
        chk("rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
        chk("rst_rdata", req_rdata, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_addr", araddr | awaddr, 32'd0);
        chk("rst_wdata_strb", wdata | 32'(wstrb) | 32'(arsize) | 32'(awsize), 32'd0);
        cyc();
        rst = 1'b0; req_en = 1'b0;
        cyc();

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Load with arready low for 5 cycles, then rvalid one cycle late.
        req_en = 1'b1; req_we = 1'b0; req_sel = 4'b1111; req_addr = 32'h1FC0_0010; req_wdata = '0;
        @(negedge clk);
        chk("bp_accept_stall", 32'(req_stall), 32'd1);
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_arvalid_%0d", i), 32'(arvalid), 32'd1);
            chk($sformatf("bp_araddr_%0d", i), araddr, 32'h1FC0_0010);
            chk($sformatf("bp_stall_%0d", i), 32'(req_stall), 32'd1);
            cyc();
        end
        arready = 1'b1;
        @(negedge clk);
        chk("bp_arvalid_hs", 32'(arvalid), 32'd1);
        cyc();
        arready = 1'b0;
        @(negedge clk);
        chk("bp_r_rready", 32'(rready), 32'd1);
        chk("bp_r_arvalid", 32'(arvalid), 32'd0);
        chk("bp_r_stall", 32'(req_stall), 32'd1);
        cyc();
        rvalid = 1'b1; rdata = 32'h0BAD_C0DE;
        @(negedge clk);
        chk("bp_rvalid_stall", 32'(req_stall), 32'd1);
        cyc();
        rvalid = 1'b0; rdata = '0;
        @(negedge clk);
        chk("bp_done_stall", 32'(req_stall), 32'd0);
        chk("bp_done_rdata", req_rdata, 32'h0BAD_C0DE);
        chk("bp_done_err", 32'(bus_err), 32'd0);
        cyc();
        req_en = 1'b0;
        cyc();

        // Store byte with wready two cycles after awready.
        req_en = 1'b1; req_we = 1'b1; req_sel = 4'b0100; req_addr = 32'h1FD0_03F8; req_wdata = 32'h00AB_0000;
        awready = 1'b1;
        @(negedge clk);
        chk("st_accept_stall", 32'(req_stall), 32'd1);
        cyc();
        @(negedge clk);
        chk("st_c1_valids", 32'({awvalid, wvalid}), 32'b11);
        chk("st_c1_awaddr", awaddr, 32'h1FD0_03F8);
        chk("st_c1_awsize", 32'(awsize), 32'd0);
        chk("st_c1_wstrb", 32'(wstrb), 32'b0100);
        cyc();
        awready = 1'b0;
        @(negedge clk);
        chk("st_c2_valids", 32'({awvalid, wvalid, bready}), 32'b010);
        cyc();
        wready = 1'b1;
        @(negedge clk);
        chk("st_c3_valids", 32'({awvalid, wvalid, bready}), 32'b010);
        chk("st_c3_wdata", wdata, 32'h00AB_0000);
        cyc();
        wready = 1'b0;
        bvalid = 1'b1;
        @(negedge clk);
        chk("st_c4_valids", 32'({awvalid, wvalid, bready}), 32'b001);
        chk("st_c4_stall", 32'(req_stall), 32'd1);
        cyc();
        bvalid = 1'b0;
        @(negedge clk);
        chk("st_done_stall", 32'(req_stall), 32'd0);
        chk("st_done_rdata", req_rdata, 32'd0);
        chk("st_done_err", 32'(bus_err), 32'd0);
        cyc();
        req_en = 1'b0;
        cyc();

        // AW and W handshake together on the entry cycle.
        req_en = 1'b1; req_we = 1'b1; req_sel = 4'b1111; req_addr = 32'h1FE0_0000; req_wdata = 32'h55AA_55AA;
        awready = 1'b1; wready = 1'b1;
        cyc();
        @(negedge clk);
        chk("sc_c1_valids", 32'({awvalid, wvalid, bready}), 32'b110);
        cyc();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        @(negedge clk);
        chk("sc_c2_valids", 32'({awvalid, wvalid, bready}), 32'b001);
        cyc();
        bvalid = 1'b0;
        @(negedge clk);
        chk("sc_done_stall", 32'(req_stall), 32'd0);
        cyc();
        req_en = 1'b0;
        cyc();

        // Reset while stuck in the write address/data phase.
        req_en = 1'b1; req_we = 1'b1; req_sel = 4'b0011; req_addr = 32'h1FD0_0200; req_wdata = 32'h0000_1111;
        cyc();
        @(negedge clk);
        chk("rw_c1_awvalid", 32'(awvalid), 32'd1);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("rw_rst_stall", 32'(req_stall), 32'd0);
        cyc();
        rst = 1'b0; req_en = 1'b0;
        @(negedge clk);
        chk("rw_after_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
        chk("rw_after_stall", 32'(req_stall), 32'd0);
        cyc();
        run_vec(7, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
